// File: rtl/piso_sipo_pkg.sv
// Shared definitions for the PISO serializer / SIPO deserializer pair.
package piso_sipo_pkg;
  localparam int                WORD_W       = 8;
  localparam logic [WORD_W-1:0] SYNC_DEFAULT = 8'hA5;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;
endpackage

// File: rtl/sipo_frame_deserializer_shift_core.sv
// MSB-first shifter with bit counter; o_word_done fires on the last bit of a word.
// Acts as the sync window in HUNT (counting disabled) and as the payload shifter in LOCKED.
module sipo_shift_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             i_clr,
  input  logic             i_shift_en,
  input  logic             i_cnt_en,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_shift_nxt,
  output logic             o_word_done
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] r_shift;
  logic [CNT_W-1:0] r_bit_cnt;
  logic             w_last_bit;

  assign o_shift_nxt = {r_shift[WIDTH-2:0], i_bit};
  assign w_last_bit  = (r_bit_cnt == CNT_W'(WIDTH - 1));
  assign o_word_done = i_shift_en & i_cnt_en & w_last_bit;

  // Clear wins over a same-cycle bit: the completed word is taken from o_shift_nxt.
  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (i_shift_en) begin
      r_shift <= o_shift_nxt;
      if (i_cnt_en) begin
        r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/sipo_frame_deserializer.sv
// Hunts for SYNC_WORD, then reassembles FRAME_LEN words onto a valid/ready port (1 clk after last bit).
// A word completing while the output is held is dropped and sets the sticky overrun flag.
module sipo_frame_deserializer
  import piso_sipo_pkg::*;
#(
  parameter int               WIDTH     = WORD_W,
  parameter logic [WIDTH-1:0] SYNC_WORD = WIDTH'(SYNC_DEFAULT),
  parameter int               FRAME_LEN = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             serial_in,
  input  logic             bit_valid,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             locked,
  output logic             frame_done,
  output logic             overrun
);
  localparam int WC_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WC_W-1:0]  r_word_cnt;
  logic [WIDTH-1:0] r_data_out;
  logic             r_data_vld;
  logic             r_frame_done;
  logic             r_overrun;

  logic             w_rst;
  logic [WIDTH-1:0] w_shift_nxt;
  logic             w_word_done;
  logic             w_sync_hit;
  logic             w_frame_end;
  logic             w_core_clr;
  logic             w_load;

  assign w_rst      = reset | ~enable;
  assign w_core_clr = w_rst | w_sync_hit | w_frame_end;
  assign w_load     = w_word_done & (~r_data_vld | data_ready);

  sipo_shift_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk        (clk),
    .i_clr      (w_core_clr),
    .i_shift_en (bit_valid),
    .i_cnt_en   (r_state == LOCKED),
    .i_bit      (serial_in),
    .o_shift_nxt(w_shift_nxt),
    .o_word_done(w_word_done)
  );

  always_ff @(posedge clk) begin
    if (w_rst) r_state <= HUNT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sync_hit  = 1'b0;
    w_frame_end = 1'b0;
    case (r_state)
      HUNT: begin
        if (bit_valid && (w_shift_nxt == SYNC_WORD)) begin
          w_sync_hit  = 1'b1;
          w_state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if (w_word_done && (r_word_cnt == WC_W'(FRAME_LEN - 1))) begin
          w_frame_end = 1'b1;
          w_state_nxt = HUNT;
        end
      end
      default: w_state_nxt = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_rst || w_sync_hit || w_frame_end) r_word_cnt <= '0;
    else if (w_word_done)                   r_word_cnt <= r_word_cnt + WC_W'(1);
  end

  // A load in the same cycle as an accept keeps valid high with the new word.
  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_data_out   <= '0;
      r_data_vld   <= 1'b0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_frame_done <= w_frame_end;
      if (w_load) begin
        r_data_out <= w_shift_nxt;
        r_data_vld <= 1'b1;
      end else if (data_ready) begin
        r_data_vld <= 1'b0;
      end
      if (w_word_done && !w_load) r_overrun <= 1'b1;
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_vld;
  assign locked     = (r_state == LOCKED);
  assign frame_done = r_frame_done;
  assign overrun    = r_overrun;
endmodule
